// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// vga_fb_arbiter : single-port framebuffer arbiter, display reads first,
// writer bounded by a starvation counter and a one-entry skid. Revision 1.0
// ============================================================================
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int             CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic              skid_valid;
  logic [ADDR_W-1:0] skid_addr;
  logic [CNT_W-1:0]  starve_cnt;
  logic [RD_LAT:0]   rd_pipe;

  logic              wr_pend;
  logic              starved;
  logic              take_skid;
  logic              take_disp;
  logic              take_wr;
  logic              take_rd;
  logic [ADDR_W-1:0] next_addr;

  // A wr_req seen while wr_ack is high is the tail of the request just served.
  always_comb begin
    wr_pend   = wr_req && !wr_ack;
    starved   = wr_pend && (starve_cnt == CNT_MAX) && !skid_valid;
    take_skid = !starved && skid_valid;
    take_disp = !starved && !skid_valid && disp_req;
    take_wr   = starved || (!skid_valid && !disp_req && wr_pend);
    take_rd   = take_skid || take_disp;
    next_addr = '0;
    if (take_wr) begin
      next_addr = wr_addr;
    end else if (take_skid) begin
      next_addr = skid_addr;
    end else if (take_disp) begin
      next_addr = disp_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_ack     <= 1'b0;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      starve_cnt <= '0;
      rd_pipe    <= '0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      mem_en    <= take_rd || take_wr;
      mem_we    <= take_wr;
      mem_addr  <= next_addr;
      mem_wdata <= take_wr ? wr_data : '0;
      wr_ack    <= take_wr;

      // Skid is only entered by a starved write and then refilled by every
      // new request while it drains, so it always holds the oldest fetch.
      if (starved || take_skid) begin
        skid_valid <= disp_req;
        if (disp_req) begin
          skid_addr <= disp_addr;
        end
      end

      if (!wr_req || take_wr) begin
        starve_cnt <= '0;
      end else if (wr_pend && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      rd_pipe    <= {rd_pipe[RD_LAT-1:0], take_rd};
      disp_valid <= rd_pipe[RD_LAT];
      if (rd_pipe[RD_LAT]) begin
        disp_data <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Single-port framebuffer memory arbiter between the VGA scan-out fetch path and a pixel writer (GPU/CPU side). Display reads have priority so scan-out never drops a pixel. The writer gets idle cycles, plus a bounded-starvation guarantee enforced through a one-entry display skid buffer. Sits between the VGA timing/fetch logic and the framebuffer RAM.

Parameters:
ADDR_W, 19, framebuffer address width (pixel index)
DATA_W, 8, pixel width
RD_LAT, 1, memory read latency in cycles (>=1), from mem_en cycle to mem_rdata valid
STARVE_MAX, 4, max consecutive waiting edges for a pending write before it is forced through (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
disp_req  in  1  one pixel fetch request per high edge, may be high every cycle
disp_addr  in  ADDR_W  fetch address, sampled with disp_req
disp_data  out  DATA_W  fetched pixel, held until next disp_valid
disp_valid  out  1  one-cycle pulse per completed fetch, in request order
wr_req  in  1  write request, held high until wr_ack
wr_addr  in  ADDR_W  write address, stable while wr_req
wr_data  in  DATA_W  write data, stable while wr_req
wr_ack  out  1  one-cycle pulse, write performed this cycle
mem_en  out  1  memory access this cycle (registered)
mem_we  out  1  write strobe (registered), only with mem_en
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after the mem_en read cycle

Behaviour:
- Reset (async, reset low): all outputs 0; skid empty; read-return pipeline cleared; starvation counter 0. In-flight reads are discarded and never produce disp_valid.
- One memory op per cycle. Decision at each edge, first match wins:
  1. Starved write: wr_req && !wr_ack && starve_cnt==STARVE_MAX && skid empty -> issue write. A simultaneous disp_req is loaded into the skid.
  2. Skid valid -> issue the skid read. A simultaneous disp_req reloads the skid, so the skid stays full.
  3. disp_req -> issue a read of disp_addr.
  4. wr_req && !wr_ack -> issue write.
  5. Otherwise mem_en=0.
- A wr_req sampled on an edge where wr_ack is high is ignored, being the tail of the acknowledged request. Max write rate: one per 2 cycles.
- Issued op: mem_en=1, with mem_we/addr/wdata set for exactly the cycle following the decision edge. wr_ack is high in that same cycle.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - +1 on each edge where wr_req && !wr_ack and the write is not granted.
  - Cleared on grant or when wr_req is low.
  - Saturates at STARVE_MAX.
- Read return: a valid-bit shift register of depth RD_LAT+1 tracks issued reads. mem_rdata is captured into disp_data on edge (issue edge + RD_LAT + 1), and disp_valid is high the following cycle.
  - Latency from the disp_req sampling edge to disp_valid high: RD_LAT+2 cycles direct, RD_LAT+3 when deferred via skid.
- Ordering: display reads complete in request order; the skid is always older than any new disp_req.
- No display request is ever lost. The skid can only fill on a starved write, and rule 1 blocks while the skid is full.
- disp_data holds its last value between pulses; disp_valid never asserts without a preceding issued read.

Test Plan:
- Single fetch, RD_LAT=1, memory model rdata=addr[7:0]: disp_req addr 0x00010 at edge 0 -> mem_en=1/mem_we=0/mem_addr=0x10 in cycle 1; disp_valid high in cycle 3 with disp_data=0x10.
- Lone write: wr_req addr 5, data 0xAB, no disp_req -> mem_en=mem_we=1, addr 5, wdata 0xAB and wr_ack high in cycle 1. A follow-up fetch of addr 5 returns 0xAB.
- Contention without starvation: disp_req for 2 cycles with wr_req held from the same edge -> both reads issued first, write issued in cycle 3, wr_ack in cycle 3.
- Starvation: STARVE_MAX=4, disp_req every cycle for 20 cycles (addrs 0..19), wr_req held from cycle 0. Required:
  - write granted on the 5th edge;
  - the concurrent read deferred via skid;
  - exactly 20 disp_valid pulses, data 0..19 in order;
  - exactly one wr_ack.
- Parameter variant RD_LAT=3: single fetch -> disp_valid 5 cycles after the request edge with correct data.
- Async reset mid-burst: drop reset with 2 reads in flight, skid full and wr_req pending -> all outputs 0 immediately (no clock edge needed). After release with no requests, no disp_valid, wr_ack or mem_en for 10 cycles.
